// File: rtl/mux_rr_reg.sv
// N-channel W-bit multiplexer with a registered output stage and valid/ready handshake.
// The source is picked by an explicit select (MODE=0) or by round-robin over valid channels (MODE=1).
module mux_rr_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 2,
  parameter int unsigned MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  chan_q;
  logic             valid_q;
  logic [SELW-1:0]  rr_ptr_q;

  logic [NCH-1:0]   grant;
  logic [SELW-1:0]  gidx;
  logic [WIDTH-1:0] gdata;
  logic             any_grant;
  logic             load;

  // Grant vector is one-hot or zero; gidx is meaningful only when any_grant is set.
  always_comb begin
    logic            found;
    int unsigned     t;
    logic [SELW-1:0] idx;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    t     = 0;
    idx   = '0;
    if (MODE == 0) begin
      if (32'(sel) < NCH) begin
        grant[sel] = in_valid[sel];
        gidx       = sel;
      end
    end else begin
      for (int unsigned j = 0; j < NCH; j++) begin
        t   = (32'(rr_ptr_q) + j) % NCH;
        idx = SELW'(t);
        if (!found && in_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gidx       = idx;
        end
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant[i]) gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign any_grant = |grant;
  assign load      = ~valid_q | out_ready;
  assign in_ready  = grant & {NCH{load}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      chan_q   <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else if (load) begin
      valid_q <= any_grant;
      if (any_grant) begin
        data_q <= gdata;
        chan_q <= gidx;
        if (MODE != 0) begin
          rr_ptr_q <= (gidx == SELW'(NCH - 1)) ? '0 : gidx + 1'b1;
        end
      end
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: one select-mode and one round-robin instance side by side.
module tb_mux_rr_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [31:0] data0, data1;
  logic [3:0]  valid0, valid1, ready0, ready1;
  logic [1:0]  sel0, sel1, chan0, chan1;
  logic [7:0]  odata0, odata1;
  logic        ovalid0, ovalid1, oready0, oready1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_rr_reg #(.WIDTH(8), .NCH(4), .SELW(2), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(data0), .in_valid(valid0), .in_ready(ready0),
    .sel(sel0), .out_data(odata0), .out_chan(chan0), .out_valid(ovalid0), .out_ready(oready0)
  );

  mux_rr_reg #(.WIDTH(8), .NCH(4), .SELW(2), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(data1), .in_valid(valid1), .in_ready(ready1),
    .sel(sel1), .out_data(odata1), .out_chan(chan1), .out_valid(ovalid1), .out_ready(oready1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned rr_seq[9] = '{0, 1, 2, 3, 0, 1, 3, 0, 3};
  logic [5:0]  seq[4];
  logic [3:0]  acc;
  int          acc_idx;
  int          n_tr;
  int          cyc;

  initial begin
    data0 = '0; data1 = '0; valid0 = '0; valid1 = '0;
    sel0 = '0; sel1 = '0; oready0 = 1'b0; oready1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(ovalid0), 0);
    check("rst_data", 32'(odata0), 0);
    check("rst_chan", 32'(chan0), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Explicit select
    sel0 = 2'd2; valid0 = 4'b0100; data0[16 +: 8] = 8'hA5; oready0 = 1'b1;
    #1 check("sel_ready", 32'(ready0), 32'h4);
    step();
    check("sel_data", 32'(odata0), 32'hA5);
    check("sel_chan", 32'(chan0), 2);
    check("sel_valid", 32'(ovalid0), 1);
    valid0 = 4'b1011;
    #1 check("sel_novalid_ready", 32'(ready0), 0);
    step();
    check("sel_drop_valid", 32'(ovalid0), 0);
    check("sel_hold_data", 32'(odata0), 32'hA5);

    // Backpressure
    valid0 = 4'b0100; data0[16 +: 8] = 8'h3C;
    step();
    check("bp_load", 32'(odata0), 32'h3C);
    oready0 = 1'b0; data0[16 +: 8] = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", 32'(ready0), 0);
      step();
      check("bp_data", 32'(odata0), 32'h3C);
      check("bp_valid", 32'(ovalid0), 1);
    end
    oready0 = 1'b1;
    #1 check("bp_release_ready", 32'(ready0), 32'h4);
    step();
    check("bp_new_data", 32'(odata0), 32'h77);
    valid0 = 4'b0000;
    step();
    check("bp_drained", 32'(ovalid0), 0);

    // Reset mid-transfer, no clock edge needed
    valid0 = 4'b0100; data0[16 +: 8] = 8'h5A; oready0 = 1'b0;
    step();
    check("mid_loaded", 32'(ovalid0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ovalid0), 0);
    check("mid_rst_data", 32'(odata0), 0);
    check("mid_rst_chan", 32'(chan0), 0);
    valid0 = '0;
    step();
    rst_n = 1'b1;

    // Round-robin: all valid, then 1001
    data1 = {8'd3, 8'd2, 8'd1, 8'd0}; oready1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      valid1 = (i < 6) ? 4'b1111 : 4'b1001;
      #1 check("rr_ready", 32'(ready1), 32'(1) << rr_seq[i]);
      step();
      check("rr_chan", 32'(chan1), rr_seq[i]);
      check("rr_data", 32'(odata1), rr_seq[i]);
    end

    // Idle keeps the pointer (0 after last grant of 3)
    valid1 = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      #1 check("idle_ready", 32'(ready1), 0);
      step();
      check("idle_valid", 32'(ovalid1), 0);
    end
    valid1 = 4'b1111;
    #1 check("idle_ptr_ready", 32'(ready1), 32'h1);
    step();
    check("idle_ptr_chan", 32'(chan1), 0);
    valid1 = 4'b0100;
    #1 check("first_valid_ready", 32'(ready1), 32'h4);
    step();
    check("first_valid_chan", 32'(chan1), 2);
    check("first_valid_out", 32'(ovalid1), 1);

    // Throughput: words tagged {chan, per-channel sequence}
    for (int i = 0; i < 4; i++) seq[i] = '0;
    n_tr = 0; cyc = 0;
    while (n_tr < 100 && cyc < 150) begin
      valid1 = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) data1[i*8 +: 8] = {2'(i), seq[i]};
      #1;
      acc = ready1;
      check("tp_onehot", 32'($countones(acc)), 1);
      acc_idx = 0;
      for (int i = 0; i < 4; i++) if (acc[i]) acc_idx = i;
      check("tp_subset", 32'(acc & ~valid1), 0);
      step();
      cyc++;
      if (acc != 0) begin
        check("tp_data", 32'(odata1), 32'({2'(acc_idx), seq[acc_idx]}));
        check("tp_chan", 32'(chan1), 32'(acc_idx));
        seq[acc_idx] = seq[acc_idx] + 6'd1;
        n_tr++;
      end
    end
    check("tp_count", 32'(n_tr), 100);
    check("tp_cycles", 32'(cyc + 1), 101);
    valid1 = '0;
    step();
    check("tp_empty", 32'(ovalid1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
